// File: rtl/change_dispenser.sv
// change_dispenser
//   Breaks one change amount into coins/notes, always taking the largest
//   denomination first, and hands each unit to the payout hopper over a
//   valid/ready handshake. Stock is tracked per denomination, and empty
//   denominations are skipped. Any amount that cannot be paid is reported as
//   a shortfall when the transaction ends.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     change_valid/ready       request handshake (ready only in IDLE)
//     change_amount            amount to pay out
//     coin_valid/ready         unit handshake toward the hopper
//     coin_denom               index of the unit on offer (0 = largest)
//     refill_en/idx/count      add units to one denomination (idx 7 ignored)
//     change_done              one-cycle end-of-transaction pulse
//     shortfall(_flag)         unpaid remainder, valid with change_done, held
//     stock_empty              bit i set while stock[i] == 0

// One denomination's stock counter. A decrement and a refill in the same
// cycle combine as sat(stock - 1 + add).
module change_dispenser_stock #(
    parameter int W    = 8,
    parameter int INIT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dec,
    input  logic         add_en,
    input  logic [W-1:0] add_cnt,
    output logic [W-1:0] stock
);
    localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

    logic [W-1:0] add_v;
    logic [W+1:0] sum;

    assign add_v = add_en ? add_cnt : {W{1'b0}};
    // Two guard bits: one for the carry out of the add, one spare. A
    // decrement only happens when stock is non-zero, so this never goes
    // below zero.
    assign sum = {2'b00, stock} + {2'b00, add_v} - {{(W+1){1'b0}}, dec};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stock <= W'(INIT);
        else if (add_en || dec)
            stock <= (sum > MAX) ? {W{1'b1}} : sum[W-1:0];
    end
endmodule

module change_dispenser #(
    parameter int total_amount_width = 16,
    parameter int stock_width        = 8,
    parameter int NUM_DENOM          = 7,
    parameter int D0                 = 100,
    parameter int D1                 = 50,
    parameter int D2                 = 20,
    parameter int D3                 = 10,
    parameter int D4                 = 5,
    parameter int D5                 = 2,
    parameter int D6                 = 1,
    parameter int INIT_STOCK         = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          change_valid,
    input  logic [total_amount_width-1:0] change_amount,
    output logic                          change_ready,
    output logic                          coin_valid,
    output logic [2:0]                    coin_denom,
    input  logic                          coin_ready,
    input  logic                          refill_en,
    input  logic [2:0]                    refill_idx,
    input  logic [stock_width-1:0]        refill_count,
    output logic                          change_done,
    output logic [total_amount_width-1:0] shortfall,
    output logic                          shortfall_flag,
    output logic [NUM_DENOM-1:0]          stock_empty
);
    typedef enum logic [1:0] {IDLE, SELECT, EMIT, DONE} state_t;

    state_t                          state, state_nxt;
    logic [total_amount_width-1:0]   remaining, remaining_nxt;
    logic [2:0]                      idx, idx_nxt;
    logic [total_amount_width-1:0]   shortfall_q;
    logic [NUM_DENOM-1:0][stock_width-1:0] stock;
    logic                            coin_hs;
    logic [total_amount_width-1:0]   d_cur;

    function automatic logic [total_amount_width-1:0] denom(input logic [2:0] i);
        case (i)
            3'd0:    denom = total_amount_width'(D0);
            3'd1:    denom = total_amount_width'(D1);
            3'd2:    denom = total_amount_width'(D2);
            3'd3:    denom = total_amount_width'(D3);
            3'd4:    denom = total_amount_width'(D4);
            3'd5:    denom = total_amount_width'(D5);
            default: denom = total_amount_width'(D6);
        endcase
    endfunction

    assign d_cur = denom(idx);

    // The unit on offer is simply the current index; it does not move while
    // in EMIT, so coin_denom stays stable until the hopper takes the unit.
    assign coin_valid   = (state == EMIT);
    assign coin_denom   = idx;
    assign coin_hs      = coin_valid && coin_ready;
    assign change_ready = (state == IDLE);
    assign change_done  = (state == DONE);

    // During DONE the live remainder is shown, so shortfall is valid in the
    // same cycle as change_done; it is latched afterwards and held.
    assign shortfall      = (state == DONE) ? remaining : shortfall_q;
    assign shortfall_flag = (shortfall != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            idx         <= '0;
            shortfall_q <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            idx       <= idx_nxt;
            if (state == DONE)
                shortfall_q <= remaining;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        idx_nxt       = idx;
        case (state)
            IDLE: begin
                if (change_valid) begin
                    remaining_nxt = change_amount;
                    idx_nxt       = '0;
                    state_nxt     = (change_amount == '0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                if (remaining >= d_cur && stock[idx] != '0)
                    state_nxt = EMIT;
                else if (idx == 3'd6 || remaining == '0)
                    state_nxt = DONE;
                else
                    idx_nxt = idx + 3'd1;
            end
            EMIT: begin
                // Go back to SELECT at the same index so one denomination
                // can be paid several times.
                if (coin_ready) begin
                    remaining_nxt = remaining - d_cur;
                    state_nxt     = SELECT;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_DENOM; i++) begin : g_stock
        change_dispenser_stock #(
            .W    (stock_width),
            .INIT (INIT_STOCK)
        ) u_stock (
            .clk     (clk),
            .rst     (rst),
            .dec     (coin_hs && (idx == 3'(i))),
            .add_en  (refill_en && (refill_idx == 3'(i))),
            .add_cnt (refill_count),
            .stock   (stock[i])
        );
        assign stock_empty[i] = (stock[i] == '0);
    end
endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
    localparam int AW = 16;
    localparam int SW = 8;
    localparam int ND = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          change_valid = 1'b0;
    logic [AW-1:0] change_amount = '0;
    logic          change_ready;
    logic          coin_valid;
    logic [2:0]    coin_denom;
    logic          coin_ready = 1'b1;
    logic          refill_en = 1'b0;
    logic [2:0]    refill_idx = '0;
    logic [SW-1:0] refill_count = '0;
    logic          change_done;
    logic [AW-1:0] shortfall;
    logic          shortfall_flag;
    logic [ND-1:0] stock_empty;

    change_dispenser dut (
        .clk            (clk),
        .rst            (rst),
        .change_valid   (change_valid),
        .change_amount  (change_amount),
        .change_ready   (change_ready),
        .coin_valid     (coin_valid),
        .coin_denom     (coin_denom),
        .coin_ready     (coin_ready),
        .refill_en      (refill_en),
        .refill_idx     (refill_idx),
        .refill_count   (refill_count),
        .change_done    (change_done),
        .shortfall      (shortfall),
        .shortfall_flag (shortfall_flag),
        .stock_empty    (stock_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int dval[7] = '{100, 50, 20, 10, 5, 2, 1};
    int ms[7];
    int exp_q[$];

    typedef struct {
        int amount;
        int ncoins;
        int sf;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stock(input string tag);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s stock[%0d]", tag, i), dut.stock[i], ms[i]);
            chk($sformatf("%s stock_empty[%0d]", tag, i), stock_empty[i], ms[i] == 0);
        end
    endtask

    // exp_n / exp_sf < 0: take coin count / shortfall from the greedy model.
    task automatic run_txn(input int amount, input int stall, input bit refill,
                           input int exp_n, input int exp_sf);
        int  rem, mn, ncoin, done_cyc, stall_left;
        bit  prev_hs, refilled;
        rem = amount;
        mn  = 0;
        for (int i = 0; i < ND; i++)
            while (rem >= dval[i] && ms[i] > 0) begin
                exp_q.push_back(i);
                rem -= dval[i];
                ms[i]--;
                mn++;
            end
        if (exp_n < 0)  exp_n  = mn;
        if (exp_sf < 0) exp_sf = rem;

        chk("ready before request", change_ready, 1);
        change_valid  = 1'b1;
        change_amount = AW'(amount);
        step;
        change_valid = 1'b0;
        coin_ready   = 1'b1;
        ncoin      = 0;
        done_cyc   = -1;
        stall_left = stall;
        prev_hs    = 1'b0;
        refilled   = 1'b0;
        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            refill_en = 1'b0;
            if (cyc == 0) chk("no coin at N+1", coin_valid, 0);
            if (prev_hs)  chk("coin gap after handshake", coin_valid, 0);
            prev_hs = 1'b0;
            if (change_done) begin
                done_cyc = cyc;
            end else if (coin_valid) begin
                if (stall_left > 0) begin
                    coin_ready = 1'b0;
                    stall_left--;
                    chk("denom stable while stalled", coin_denom,
                        (exp_q.size() > 0) ? exp_q[0] : -1);
                end else begin
                    coin_ready = 1'b1;
                end
                if (coin_ready) begin
                    if (exp_q.size() == 0) chk("unexpected coin denom", coin_denom, -1);
                    else                   chk("coin denom", coin_denom, exp_q.pop_front());
                    ncoin++;
                    prev_hs = 1'b1;
                    if (refill && !refilled) begin
                        refill_en    = 1'b1;
                        refill_idx   = 3'd0;
                        refill_count = 8'd10;
                        refilled     = 1'b1;
                    end
                end
            end
            if (done_cyc < 0) step;
        end
        refill_en = 1'b0;
        chk("change_done seen", done_cyc >= 0, 1);
        if (amount == 0) chk("zero amount done latency", done_cyc, 0);
        chk("coin count", ncoin, exp_n);
        chk("shortfall", shortfall, exp_sf);
        chk("shortfall_flag", shortfall_flag, exp_sf != 0);
        step;
        chk("done is one cycle", change_done, 0);
        chk("shortfall held", shortfall, exp_sf);
        chk("ready after done", change_ready, 1);
        if (refill) ms[0] = (ms[0] + 10 > 255) ? 255 : ms[0] + 10;
        chk_stock($sformatf("after %0d", amount));
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{87,  5, 0};
        tbl[1] = '{0,   0, 0};
        tbl[2] = '{188, 7, 0};
        tbl[3] = '{1,   1, 0};
        tbl[4] = '{3,   2, 0};
        tbl[5] = '{100, 1, 0};
        tbl[6] = '{7,   2, 0};
        tbl[7] = '{100, 1, 0};
        for (int i = 0; i < ND; i++) ms[i] = 255;

        // Reset state
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
        step;
        chk("reset change_ready", change_ready, 1);
        chk("reset coin_valid", coin_valid, 0);
        chk("reset coin_denom", coin_denom, 0);
        chk("reset change_done", change_done, 0);
        chk("reset shortfall", shortfall, 0);
        chk("reset shortfall_flag", shortfall_flag, 0);
        chk_stock("reset");

        // Table of full-stock transactions
        for (int t = 0; t < 8; t++)
            run_txn(tbl[t].amount, 0, 1'b0, tbl[t].ncoins, tbl[t].sf);

        // 250 with the hopper stalling the first unit for 5 cycles
        run_txn(250, 5, 1'b0, 3, 0);

        // Refill of D0 on the same edge as a D0 handshake, saturating
        chk("stock[0] before refill", dut.stock[0], 250);
        run_txn(100, 0, 1'b1, 1, 0);
        chk("stock[0] saturated", dut.stock[0], 255);

        // Refill index 7 is ignored
        refill_en    = 1'b1;
        refill_idx   = 3'd7;
        refill_count = 8'd50;
        step;
        refill_en = 1'b0;
        step;
        chk_stock("refill idx 7");

        // Drain the 2 and 1 stock, then expect a full shortfall
        while (ms[5] > 0 || ms[6] > 0) run_txn(3, 0, 1'b0, -1, -1);
        run_txn(3, 0, 1'b0, 0, 3);
        chk("stock_empty[6:5]", stock_empty[6:5], 2'b11);

        // Plain refill brings a denomination back
        refill_en    = 1'b1;
        refill_idx   = 3'd5;
        refill_count = 8'd3;
        step;
        refill_en = 1'b0;
        ms[5] = 3;
        chk_stock("refill idx 5");

        // Reset in the middle of a transaction
        coin_ready    = 1'b0;
        change_valid  = 1'b1;
        change_amount = 16'd250;
        step;
        change_valid = 1'b0;
        for (int k = 0; k < 10 && !coin_valid; k++) step;
        chk("coin_valid before reset", coin_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("coin_valid drops on reset", coin_valid, 0);
        chk("no done on reset", change_done, 0);
        step;
        step;
        rst = 1'b0;
        for (int i = 0; i < ND; i++) ms[i] = 255;
        chk("ready after reset", change_ready, 1);
        chk_stock("mid reset");
        coin_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step;
            chk("no done after abort", change_done, 0);
            chk("no coin after abort", coin_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
